fir_band_sched: RTL and testbench

// Time-multiplexes one shared FIR MAC core across NBANDS equalizer bands (LP..HP).
// Per input sample it runs each enabled band in turn: clears the accumulator, walks the

---
 rtl/eq_pkg.sv | 21 ++
 rtl/fir_tap_cnt.sv | 44 ++++
 rtl/fir_band_sched.sv | 209 ++++++++++++++++++++
 tb/tb_fir_band_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer FIR band scheduler.
// Holds the scheduler state encoding, default band count and band indices.
package eq_pkg;

    localparam int NBANDS_DEF = 5;

    localparam int BAND_LP  = 0;
    localparam int BAND_LM  = 1;
    localparam int BAND_MID = 2;
    localparam int BAND_HM  = 3;
    localparam int BAND_HP  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        WRB
    } sched_state_t;

endpackage

// File: rtl/fir_tap_cnt.sv
// Tap counter for the shared FIR core: coefficient address with clear/increment,
// last-tap flag, and a ROM_LAT-deep delay line turning RUN-valid into acc_en.
// Ports: clk, rst (async, active high), i_clr, i_inc, i_run -> o_cnt, o_last, o_acc_en.
module fir_tap_cnt #(
    parameter int NTAPS   = 1023,
    parameter int ADDR_W  = 10,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_cnt,
    output logic              o_last,
    output logic              o_acc_en
);

    logic [ADDR_W-1:0]  r_cnt;
    logic [ROM_LAT-1:0] r_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_dly <= '0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // acc_en follows each RUN cycle once the ROM data has arrived
            r_dly[0] <= i_run;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last   = (r_cnt == ADDR_W'(NTAPS - 1));
    assign o_acc_en = r_dly[ROM_LAT-1];

endmodule

// File: rtl/fir_band_sched.sv
// Time-multiplexes one FIR MAC core across NBANDS equalizer bands per input sample.
// Ports: clk, rst, smpl_vld, band_en, ovr_clr -> band_sel, cff_ptr, sequencing,
//        acc_clr, acc_en, result_wr, done, busy, overrun.
module fir_band_sched
    import eq_pkg::*;
#(
    parameter int NBANDS  = NBANDS_DEF,
    parameter int NTAPS   = 1023,
    parameter int ADDR_W  = 10,
    parameter int ROM_LAT = 1,
    localparam int SEL_W  = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smpl_vld,
    input  logic [NBANDS-1:0] band_en,
    input  logic              ovr_clr,
    output logic [SEL_W-1:0]  band_sel,
    output logic [ADDR_W-1:0] cff_ptr,
    output logic              sequencing,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              result_wr,
    output logic              done,
    output logic              busy,
    output logic              overrun
);

    localparam int DRN_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    sched_state_t      r_state;
    logic [NBANDS-1:0] r_en;
    logic [SEL_W-1:0]  r_band_sel;
    logic [DRN_W-1:0]  r_drn;
    logic              r_seq;
    logic              r_clr;
    logic              r_wr;
    logic              r_done;
    logic              r_busy;
    logic              r_pend;
    logic              r_ovr;

    logic              w_lo_vld;
    logic [SEL_W-1:0]  w_lo_sel;
    logic              w_nx_vld;
    logic [SEL_W-1:0]  w_nx_sel;
    logic              w_last;
    logic              w_acc_en;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_run;
    logic              w_fin;
    logic              w_drop;

    // lowest enabled band in the live mask: first band of a new job
    always_comb begin
        w_lo_vld = 1'b0;
        w_lo_sel = '0;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (band_en[i]) begin
                w_lo_vld = 1'b1;
                w_lo_sel = SEL_W'(i);
            end
        end
    end

    // next enabled band strictly above the current one in the frozen mask
    always_comb begin
        w_nx_vld = 1'b0;
        w_nx_sel = '0;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (r_en[i] && (i > int'(r_band_sel))) begin
                w_nx_vld = 1'b1;
                w_nx_sel = SEL_W'(i);
            end
        end
    end

    assign w_run     = (r_state == RUN);
    assign w_cnt_inc = w_run && !w_last;
    // clearing in WRB puts the pointer at 0 for the following CLR or IDLE
    assign w_cnt_clr = (r_state == IDLE) || (r_state == WRB);
    assign w_fin     = (r_state == WRB) && !w_nx_vld;
    assign w_drop    = smpl_vld && (r_state != IDLE) && r_pend;

    fir_tap_cnt #(
        .NTAPS   (NTAPS),
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT)
    ) u_tap_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_cnt_inc),
        .i_run    (w_run),
        .o_cnt    (w_ptr),
        .o_last   (w_last),
        .o_acc_en (w_acc_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_en       <= '0;
            r_band_sel <= SEL_W'(BAND_LP);
            r_drn      <= '0;
            r_seq      <= 1'b0;
            r_clr      <= 1'b0;
            r_wr       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_clr  <= 1'b0;
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (smpl_vld) begin
                        r_en <= band_en;
                        if (w_lo_vld) begin
                            r_state    <= CLR;
                            r_band_sel <= w_lo_sel;
                            r_clr      <= 1'b1;
                            r_seq      <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= DRAIN;
                        r_drn   <= '0;
                    end
                end
                DRAIN: begin
                    if (r_drn == DRN_W'(ROM_LAT - 1)) begin
                        r_state <= WRB;
                        r_seq   <= 1'b0;
                        r_wr    <= 1'b1;
                        r_done  <= !w_nx_vld;
                    end else begin
                        r_drn <= r_drn + 1'b1;
                    end
                end
                WRB: begin
                    if (w_nx_vld) begin
                        r_state    <= CLR;
                        r_band_sel <= w_nx_sel;
                        r_clr      <= 1'b1;
                        r_seq      <= 1'b1;
                    end else if (r_pend || smpl_vld) begin
                        // queued sample: restart without passing through IDLE
                        r_en <= band_en;
                        if (w_lo_vld) begin
                            r_state    <= CLR;
                            r_band_sel <= w_lo_sel;
                            r_clr      <= 1'b1;
                            r_seq      <= 1'b1;
                        end else begin
                            r_state    <= IDLE;
                            r_band_sel <= '0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end else begin
                        r_state    <= IDLE;
                        r_band_sel <= '0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_fin) begin
                r_pend <= 1'b0;
            end else if (smpl_vld && (r_state != IDLE)) begin
                r_pend <= 1'b1;
            end
            // a fresh drop wins over a simultaneous clear
            r_ovr <= (r_ovr && !ovr_clr) || w_drop;
        end
    end

    assign band_sel   = r_band_sel;
    assign cff_ptr    = w_ptr;
    assign sequencing = r_seq;
    assign acc_clr    = r_clr;
    assign acc_en     = w_acc_en;
    assign result_wr  = r_wr;
    assign done       = r_done;
    assign busy       = r_busy;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_fir_band_sched.sv
// Self-checking bench for fir_band_sched with NTAPS=8, ROM_LAT=1, NBANDS=5.
// Job-level vectors, a randomized run against a schedule model, and corner sequences.
module tb_fir_band_sched;

    localparam int NB = 5;
    localparam int NT = 8;
    localparam int AW = 10;
    localparam int RL = 1;
    localparam int SW = 3;
    localparam int BC = NT + RL + 2;
    localparam int NS = 650;
    localparam int NR = 800;

    logic          clk = 1'b0;
    logic          rst;
    logic          smpl_vld;
    logic [NB-1:0] band_en;
    logic          ovr_clr;
    logic [SW-1:0] band_sel;
    logic [AW-1:0] cff_ptr;
    logic          sequencing;
    logic          acc_clr;
    logic          acc_en;
    logic          result_wr;
    logic          done;
    logic          busy;
    logic          overrun;

    fir_band_sched #(
        .NBANDS  (NB),
        .NTAPS   (NT),
        .ADDR_W  (AW),
        .ROM_LAT (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .smpl_vld   (smpl_vld),
        .band_en    (band_en),
        .ovr_clr    (ovr_clr),
        .band_sel   (band_sel),
        .cff_ptr    (cff_ptr),
        .sequencing (sequencing),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .result_wr  (result_wr),
        .done       (done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        smpl_vld = 1'b0;
        ovr_clr = 1'b0;
        band_en = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NB-1:0] mask;
        int done_cyc;
        int nwr;
        int nacc;
        int nseq;
    } vec_t;

    // expected per-cycle schedule for the random run
    bit e_busy[NR];
    bit e_seq[NR];
    bit e_clr[NR];
    bit e_acc[NR];
    bit e_wr[NR];
    bit e_done[NR];
    bit e_ovr[NR];
    bit e_pcare[NR];
    int e_ptr[NR];
    int e_bsel[NR];
    bit s_vld[NR];
    bit s_clr[NR];
    logic [NB-1:0] s_en[NR];

    // lay out one job whose first CLR is at cycle s; e = its final WRB cycle
    task automatic fill_job(input int s, input logic [NB-1:0] m, output int e);
        int j;
        j = 0;
        for (int b = 0; b < NB; b++) begin
            if (m[b]) begin
                int base;
                base = s + BC * j;
                e_clr[base] = 1'b1;
                for (int t = 0; t < BC; t++) e_bsel[base + t] = b;
                for (int t = 0; t <= NT + RL; t++) begin
                    e_seq[base + t] = 1'b1;
                    e_pcare[base + t] = 1'b1;
                end
                e_ptr[base] = 0;
                for (int t = 0; t < NT; t++) begin
                    e_ptr[base + 1 + t] = t;
                    e_acc[base + 1 + RL + t] = 1'b1;
                end
                for (int t = 0; t < RL; t++) e_ptr[base + 1 + NT + t] = NT - 1;
                e_wr[base + BC - 1] = 1'b1;
                j++;
            end
        end
        e = s + BC * j - 1;
        for (int c = s; c <= e; c++) e_busy[c] = 1'b1;
        e_done[e] = 1'b1;
    endtask

    initial begin
        vec_t tbl[6];
        int n, dc, nwr, nacc, nseq, nclr, nbusy, ndone, nbad;
        bit got;
        logic [NB-1:0] wrmask;
        int jend;
        bit pend, drop;

        tbl[0] = '{5'b11111, 56, 5, 40, 50};
        tbl[1] = '{5'b10010, 23, 2, 16, 20};
        tbl[2] = '{5'b00000, 2, 0, 0, 0};
        tbl[3] = '{5'b00001, 12, 1, 8, 10};
        tbl[4] = '{5'b10000, 12, 1, 8, 10};
        tbl[5] = '{5'b01100, 23, 2, 16, 20};

        // reset state
        rst = 1'b1;
        smpl_vld = 1'b0;
        ovr_clr = 1'b0;
        band_en = '0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_seq", sequencing, 0);
        chk("rst_done", done, 0);
        chk("rst_wr", result_wr, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_bsel", band_sel, 0);
        chk("rst_ptr", cff_ptr, 0);
        chk("rst_clr_acc", {acc_clr, acc_en}, 0);
        rst = 1'b0;
        tick();

        // job-level vectors; the pulse cycle is cycle 1
        foreach (tbl[v]) begin
            do_reset();
            band_en = tbl[v].mask;
            smpl_vld = 1'b1;
            tick();
            smpl_vld = 1'b0;
            band_en = ~tbl[v].mask;
            n = 2;
            got = 1'b0;
            dc = -1;
            nwr = 0; nacc = 0; nseq = 0; nclr = 0; nbusy = 0;
            wrmask = '0;
            while (n <= 200 && !got) begin
                if (result_wr) begin
                    nwr++;
                    wrmask[band_sel] = 1'b1;
                end
                if (acc_clr) chk($sformatf("v%0d_ptr_at_clr", v), cff_ptr, 0);
                nacc += int'(acc_en);
                nseq += int'(sequencing);
                nclr += int'(acc_clr);
                nbusy += int'(busy);
                if (done) begin
                    got = 1'b1;
                    dc = n;
                end else begin
                    tick();
                    n++;
                end
            end
            chk($sformatf("v%0d_done_cyc", v), dc, tbl[v].done_cyc);
            chk($sformatf("v%0d_nwr", v), nwr, tbl[v].nwr);
            chk($sformatf("v%0d_wrmask", v), wrmask, tbl[v].mask);
            chk($sformatf("v%0d_nacc", v), nacc, tbl[v].nacc);
            chk($sformatf("v%0d_nseq", v), nseq, tbl[v].nseq);
            chk($sformatf("v%0d_nclr", v), nclr, tbl[v].nwr);
            chk($sformatf("v%0d_nbusy", v), nbusy, tbl[v].nwr * BC);
            tick();
            chk($sformatf("v%0d_after_busy", v), busy, 0);
            chk($sformatf("v%0d_after_done", v), done, 0);
        end

        // randomized run against the job-level schedule model
        for (int c = 0; c < NR; c++) begin
            s_vld[c] = (c < NS) && ($urandom_range(0, 19) == 0);
            s_en[c] = ($urandom_range(0, 5) == 0) ? NB'(0) : NB'($urandom_range(1, 31));
            s_clr[c] = (c < NS) && ($urandom_range(0, 29) == 0);
        end
        jend = -1;
        pend = 1'b0;
        e_ovr[0] = 1'b0;
        for (int c = 0; c < NR - 1; c++) begin
            drop = 1'b0;
            if (c > jend) begin
                if (s_vld[c]) begin
                    if (s_en[c] == 0) e_done[c + 1] = 1'b1;
                    else fill_job(c + 1, s_en[c], jend);
                end
            end else begin
                if (s_vld[c]) begin
                    if (pend) drop = 1'b1;
                    else pend = 1'b1;
                end
                if (c == jend && pend) begin
                    pend = 1'b0;
                    if (s_en[c] == 0) e_done[c + 1] = 1'b1;
                    else fill_job(c + 1, s_en[c], jend);
                end
            end
            e_ovr[c + 1] = (e_ovr[c] && !s_clr[c]) || drop;
        end

        do_reset();
        for (int c = 0; c < NR; c++) begin
            smpl_vld = s_vld[c];
            band_en = s_en[c];
            ovr_clr = s_clr[c];
            chk($sformatf("rnd_busy@%0d", c), busy, e_busy[c]);
            chk($sformatf("rnd_seq@%0d", c), sequencing, e_seq[c]);
            chk($sformatf("rnd_accclr@%0d", c), acc_clr, e_clr[c]);
            chk($sformatf("rnd_accen@%0d", c), acc_en, e_acc[c]);
            chk($sformatf("rnd_wr@%0d", c), result_wr, e_wr[c]);
            chk($sformatf("rnd_done@%0d", c), done, e_done[c]);
            chk($sformatf("rnd_ovr@%0d", c), overrun, e_ovr[c]);
            if (e_pcare[c]) chk($sformatf("rnd_ptr@%0d", c), cff_ptr, e_ptr[c]);
            if (e_seq[c] || e_wr[c]) chk($sformatf("rnd_bsel@%0d", c), band_sel, e_bsel[c]);
            tick();
        end

        // back-to-back jobs, overrun, clear, and clear colliding with a new drop
        do_reset();
        band_en = 5'b00011;
        ndone = 0;
        for (int c = 0; c <= 70; c++) begin
            smpl_vld = (c == 0) || (c == 5) || (c == 8) || (c == 30) || (c == 31);
            ovr_clr = (c == 15) || (c == 31);
            ndone += int'(done);
            if (c == 9) chk("b2b_ovr_set", overrun, 1);
            if (c == 16) chk("b2b_ovr_clr", overrun, 0);
            if (c == 22) chk("b2b_done1", done, 1);
            if (c == 22) chk("b2b_busy22", busy, 1);
            if (c == 23) chk("b2b_busy23", busy, 1);
            if (c == 23) chk("b2b_clr23", acc_clr, 1);
            if (c == 23) chk("b2b_bsel23", band_sel, 0);
            if (c == 32) chk("b2b_ovr_collide", overrun, 1);
            if (c == 44) chk("b2b_done2", done, 1);
            if (c == 45) chk("b2b_clr45", acc_clr, 1);
            if (c == 66) chk("b2b_done3", done, 1);
            if (c == 67) chk("b2b_idle67", busy, 0);
            tick();
        end
        smpl_vld = 1'b0;
        ovr_clr = 1'b0;
        chk("b2b_ndone", ndone, 3);

        // async reset during RUN of band 2
        do_reset();
        band_en = 5'b11111;
        for (int c = 0; c < 27; c++) begin
            smpl_vld = (c == 0);
            tick();
        end
        smpl_vld = 1'b0;
        chk("ar_bsel_before", band_sel, 2);
        chk("ar_ptr_before", cff_ptr, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_seq", sequencing, 0);
        chk("ar_bsel", band_sel, 0);
        chk("ar_ptr", cff_ptr, 0);
        chk("ar_misc", {acc_clr, acc_en, result_wr, done, overrun}, 0);
        tick();
        rst = 1'b0;
        nbad = 0;
        for (int c = 0; c < 6; c++) begin
            nbad += int'(result_wr) + int'(done) + int'(busy);
            tick();
        end
        chk("ar_quiet", nbad, 0);
        smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        chk("ar_restart_clr", acc_clr, 1);
        chk("ar_restart_bsel", band_sel, 0);
        for (int c = 0; c < BC - 1; c++) tick();
        chk("ar_first_wr", result_wr, 1);
        chk("ar_first_wr_bsel", band_sel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
